// File: rtl/pow_res_credit_fifo.sv
// Credit-gated result collector for the pow_5 / pow_n pipes: issues arguments only
// when a FIFO slot is reserved, buffers the backpressure-free results, drains via valid/ready.
module pow_res_credit_fifo #(
    parameter int w     = 8,
    parameter int depth = 8,
    localparam int cw   = $clog2(depth) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          arg_vld,
    output logic          arg_rdy,
    output logic          pipe_arg_vld,
    input  logic          res_vld,
    input  logic [w-1:0]  res,
    output logic          out_vld,
    output logic [w-1:0]  out_data,
    input  logic          out_rdy,
    output logic [cw-1:0] credits,
    output logic [cw-1:0] occupancy,
    output logic          overflow
);

    localparam int aw = $clog2(depth);
    localparam logic [cw-1:0] depth_c = cw'(depth);

    logic [w-1:0]  mem [depth];
    logic [aw-1:0] wr_ptr;
    logic [aw-1:0] rd_ptr;
    logic [cw-1:0] credits_q;
    logic [cw-1:0] occ_q;
    logic          overflow_q;

    logic fire;
    logic pop;
    logic full;
    logic wr_en;
    logic ovf_set;

    always_comb begin
        arg_rdy      = (credits_q != '0);
        fire         = arg_vld & arg_rdy;
        pipe_arg_vld = fire;
        out_vld      = (occ_q != '0);
        pop          = out_vld & out_rdy;
        full         = (occ_q == depth_c);
        wr_en        = res_vld & (~full | pop);
        ovf_set      = res_vld & full & ~pop;
        out_data     = mem[rd_ptr];
        credits      = credits_q;
        occupancy    = occ_q;
        overflow     = overflow_q;
    end

    // Increment is held at depth so a protocol violation upstream cannot mint credits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_q <= depth_c;
        end else if (fire && !pop) begin
            credits_q <= credits_q - cw'(1);
        end else if (pop && !fire && credits_q != depth_c) begin
            credits_q <= credits_q + cw'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            case ({wr_en, pop})
                2'b10:   occ_q <= occ_q + cw'(1);
                2'b01:   occ_q <= occ_q - cw'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + aw'(1);
            if (pop)   rd_ptr <= rd_ptr + aw'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (ovf_set) begin
            overflow_q <= 1'b1;
        end
    end

    // Storage is intentionally unreset; out_data is only meaningful with out_vld.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= res;
    end

endmodule

// File: tb/tb_pow_res_credit_fifo.sv
// Bench for pow_res_credit_fifo: a behavioural x^5 mod 256 pipe feeds the DUT, and a
// scoreboard queue holds expected results in issue order.
module tb_pow_res_credit_fifo;

    localparam int W     = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int L     = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          arg_vld = 1'b0;
    logic          arg_rdy;
    logic          pipe_arg_vld;
    logic          res_vld;
    logic [W-1:0]  res;
    logic          out_vld;
    logic [W-1:0]  out_data;
    logic          out_rdy = 1'b0;
    logic [CW-1:0] credits;
    logic [CW-1:0] occupancy;
    logic          overflow;

    logic [W-1:0]  arg = '0;
    logic          force_vld = 1'b0;
    logic [W-1:0]  force_res = '0;

    int n_cmp = 0;
    int n_err = 0;
    int fire_count = 0;
    logic [W-1:0] sb_q [$];

    always #5 clk = ~clk;

    pow_res_credit_fifo #(.w(W), .depth(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arg_vld      (arg_vld),
        .arg_rdy      (arg_rdy),
        .pipe_arg_vld (pipe_arg_vld),
        .res_vld      (res_vld),
        .res          (res),
        .out_vld      (out_vld),
        .out_data     (out_data),
        .out_rdy      (out_rdy),
        .credits      (credits),
        .occupancy    (occupancy),
        .overflow     (overflow)
    );

    function automatic logic [W-1:0] pow5(input logic [W-1:0] x);
        int unsigned p;
        p = x;
        p = p * x;
        p = p * x;
        p = p * x;
        p = p * x;
        return W'(p);
    endfunction

    // Behavioural pow unit: L registered stages, no backpressure, shares rst_n.
    logic [L-1:0] pv;
    logic [W-1:0] pd [0:L-1];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
        end else begin
            pv    <= {pv[L-2:0], pipe_arg_vld};
            pd[0] <= pow5(arg);
            for (int k = 1; k < L; k++) pd[k] <= pd[k-1];
        end
    end
    assign res_vld = force_vld ? 1'b1 : pv[L-1];
    assign res     = force_vld ? force_res : pd[L-1];

    // Scoreboard: push on issue, pop and compare on consumer acceptance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pipe_arg_vld) begin
                sb_q.push_back(pow5(arg));
                fire_count++;
            end
            if (out_vld && out_rdy) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL pop_unexpected: out_data=%0d, required no pop", out_data);
                end else begin
                    if (out_data !== sb_q[0]) begin
                        n_err++;
                        $display("FAIL pop_data: out_data=%0d, required %0d", out_data, sb_q[0]);
                    end
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(output bit ok);
        int n;
        n = 0;
        while (out_vld && n < 200) begin
            step();
            n++;
        end
        ok = !out_vld;
    endtask

    task automatic fill_stalled(input int count);
        out_rdy = 1'b0;
        for (int i = 0; i < count; i++) begin
            arg = W'(i & 7);
            arg_vld = 1'b1;
            step();
        end
        arg_vld = 1'b0;
        repeat (L + 2) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        arg_vld = 1'b0;
        out_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        n_cmp++; if (arg_rdy !== 1'b1) begin n_err++; $display("FAIL reset_arg_rdy: got %b, required 1", arg_rdy); end
        n_cmp++; if (credits !== CW'(DEPTH)) begin n_err++; $display("FAIL reset_credits: got %0d, required %0d", credits, DEPTH); end
        n_cmp++; if (occupancy !== '0) begin n_err++; $display("FAIL reset_occupancy: got %0d, required 0", occupancy); end
        n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL reset_out_vld: got %b, required 0", out_vld); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
    endtask

    task automatic test_single();
        int lat;
        int f0;
        step();
        f0 = fire_count;
        arg = 8'd3;
        arg_vld = 1'b1;
        #1;
        n_cmp++; if (pipe_arg_vld !== 1'b1) begin n_err++; $display("FAIL single_pipe_vld: got %b, required 1", pipe_arg_vld); end
        step();
        arg_vld = 1'b0;
        #1;
        n_cmp++; if (credits !== CW'(DEPTH - 1)) begin n_err++; $display("FAIL single_credits: got %0d, required %0d", credits, DEPTH - 1); end
        lat = 0;
        while (!out_vld && lat < 20) begin
            step();
            lat++;
        end
        n_cmp++; if (fire_count - f0 !== 1) begin n_err++; $display("FAIL single_fires: got %0d, required 1", fire_count - f0); end
        n_cmp++; if (lat !== L) begin n_err++; $display("FAIL single_latency: got %0d edges after fire edge, required %0d", lat, L); end
        n_cmp++; if (out_data !== 8'd243) begin n_err++; $display("FAIL single_data: got %0d, required 243", out_data); end
        n_cmp++; if (occupancy !== CW'(1)) begin n_err++; $display("FAIL single_occupancy: got %0d, required 1", occupancy); end
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;
        #1;
        n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL single_drained: got %b, required 0", out_vld); end
        n_cmp++; if (credits !== CW'(DEPTH)) begin n_err++; $display("FAIL single_credit_return: got %0d, required %0d", credits, DEPTH); end
    endtask

    task automatic test_fill();
        int f0;
        bit ok;
        f0 = fire_count;
        out_rdy = 1'b0;
        for (int i = 0; i < 12; i++) begin
            arg = W'(i & 7);
            arg_vld = 1'b1;
            #1;
            n_cmp++;
            if (arg_rdy !== (i < DEPTH)) begin
                n_err++;
                $display("FAIL fill_arg_rdy[%0d]: got %b, required %b", i, arg_rdy, (i < DEPTH));
            end
            step();
        end
        arg_vld = 1'b0;
        repeat (L + 2) step();
        n_cmp++; if (fire_count - f0 !== DEPTH) begin n_err++; $display("FAIL fill_fires: got %0d, required %0d", fire_count - f0, DEPTH); end
        n_cmp++; if (occupancy !== CW'(DEPTH)) begin n_err++; $display("FAIL fill_occupancy: got %0d, required %0d", occupancy, DEPTH); end
        n_cmp++; if (credits !== '0) begin n_err++; $display("FAIL fill_credits: got %0d, required 0", credits); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fill_overflow: got %b, required 0", overflow); end
        n_cmp++; if (sb_q.size() != DEPTH || sb_q[7] !== 8'd167) begin n_err++; $display("FAIL fill_expected_tail: queue size %0d, required %0d ending in 167", sb_q.size(), DEPTH); end
        out_rdy = 1'b1;
        wait_empty(ok);
        out_rdy = 1'b0;
        n_cmp++; if (!ok || sb_q.size() != 0) begin n_err++; $display("FAIL fill_drain: %0d results outstanding, required 0", sb_q.size()); end
    endtask

    task automatic test_stream();
        bit ok;
        out_rdy = 1'b1;
        for (int i = 0; i < 50; i++) begin
            arg = W'(i & 7);
            arg_vld = 1'b1;
            #1;
            n_cmp++;
            if (pipe_arg_vld !== 1'b1) begin n_err++; $display("FAIL stream_pipe_vld[%0d]: got %b, required 1", i, pipe_arg_vld); end
            if (i >= L + 1) begin
                n_cmp++;
                if (out_vld !== 1'b1) begin n_err++; $display("FAIL stream_gap[%0d]: out_vld=%b, required 1", i, out_vld); end
                n_cmp++;
                if (credits !== CW'(2)) begin n_err++; $display("FAIL stream_credits[%0d]: got %0d, required 2", i, credits); end
                n_cmp++;
                if (occupancy !== CW'(1)) begin n_err++; $display("FAIL stream_occupancy[%0d]: got %0d, required 1", i, occupancy); end
            end
            step();
        end
        arg_vld = 1'b0;
        repeat (L + 1) step();
        wait_empty(ok);
        out_rdy = 1'b0;
        n_cmp++; if (!ok || sb_q.size() != 0) begin n_err++; $display("FAIL stream_drain: %0d results outstanding, required 0", sb_q.size()); end
    endtask

    task automatic test_simultaneous();
        bit ok;
        fill_stalled(DEPTH);
        force_res = 8'h5A;
        force_vld = 1'b1;
        out_rdy = 1'b1;
        sb_q.push_back(8'h5A);
        step();
        force_vld = 1'b0;
        out_rdy = 1'b0;
        #1;
        n_cmp++; if (occupancy !== CW'(DEPTH)) begin n_err++; $display("FAIL simul_full_occupancy: got %0d, required %0d", occupancy, DEPTH); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL simul_full_overflow: got %b, required 0", overflow); end
        out_rdy = 1'b1;
        wait_empty(ok);
        out_rdy = 1'b0;
        n_cmp++; if (!ok || sb_q.size() != 0) begin n_err++; $display("FAIL simul_drain: %0d results outstanding, required 0", sb_q.size()); end
        n_cmp++; if (credits !== CW'(DEPTH)) begin n_err++; $display("FAIL simul_credits_cap: got %0d, required %0d", credits, DEPTH); end
    endtask

    task automatic test_overflow_reset();
        bit ok;
        fill_stalled(DEPTH);
        force_res = 8'hAA;
        force_vld = 1'b1;
        step();
        force_vld = 1'b0;
        #1;
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b, required 1", overflow); end
        n_cmp++; if (occupancy !== CW'(DEPTH)) begin n_err++; $display("FAIL ovf_occupancy: got %0d, required %0d", occupancy, DEPTH); end
        repeat (3) step();
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
        out_rdy = 1'b1;
        wait_empty(ok);
        out_rdy = 1'b0;
        n_cmp++; if (!ok || sb_q.size() != 0) begin n_err++; $display("FAIL ovf_drain: %0d results outstanding, required 0", sb_q.size()); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky_after_drain: got %b, required 1", overflow); end
        fill_stalled(3);
        n_cmp++; if (occupancy !== CW'(3)) begin n_err++; $display("FAIL prereset_occupancy: got %0d, required 3", occupancy); end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL async_out_vld: got %b, required 0", out_vld); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL async_overflow: got %b, required 0", overflow); end
        n_cmp++; if (occupancy !== '0) begin n_err++; $display("FAIL async_occupancy: got %0d, required 0", occupancy); end
        n_cmp++; if (credits !== CW'(DEPTH)) begin n_err++; $display("FAIL async_credits: got %0d, required %0d", credits, DEPTH); end
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_simultaneous();
        test_overflow_reset();
        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
